// File: rtl/fifo_gen2.sv
// fifo_gen2: synchronous FIFO with wrap-bit pointers, threshold flags,
// one-cycle error pulses, sticky error bits and optional first-word-fall-through.
module fifo_gen2 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = 12,
   parameter int AE_THRESH  = 4,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  push_err_on_full,
   output logic                  pop_err_on_empty,
   output logic                  ovf_sticky,
   output logic                  udf_sticky
);
   localparam logic [ADDR_WIDTH:0] LP_AF  = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] LP_AE  = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] LP_ONE = (ADDR_WIDTH+1)'(1);
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_dout;
   logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
   logic                  w_push_ok, w_pop_ok;
   assign empty        = r_wr_ptr == r_rd_ptr;
   assign full         = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                         (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
   assign count        = r_wr_ptr - r_rd_ptr;
   assign almost_full  = count >= LP_AF;
   assign almost_empty = count <= LP_AE;
   assign w_push_ok    = push & ~full;
   assign w_pop_ok     = pop & ~empty;
   assign data_out     = (FWFT != 0) ? r_mem[r_rd_ptr[ADDR_WIDTH-1:0]] : r_dout;
   // Memory is deliberately left out of reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_dout           <= '0;
         push_err_on_full <= 1'b0;
         pop_err_on_empty <= 1'b0;
         ovf_sticky       <= 1'b0;
         udf_sticky       <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + LP_ONE;
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + LP_ONE;
            r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
         end
         push_err_on_full <= push & full;
         pop_err_on_empty <= pop & empty;
         ovf_sticky       <= (push & full) | (ovf_sticky & ~clr_err);
         udf_sticky       <= (pop & empty) | (udf_sticky & ~clr_err);
      end
   end
endmodule

// File: tb/tb_fifo_gen2.sv
// tb_fifo_gen2: directed self-checking bench; a registered-read and an FWFT
// instance share stimulus, expected data comes from a behavioural queue.
module tb_fifo_gen2;
   logic       clk = 0, rst_n = 0, push = 0, pop = 0, clr_err = 0;
   logic [7:0] data_in = 0;
   logic [7:0] data_out, f_data_out;
   logic       full, empty, almost_full, almost_empty, push_err_on_full, pop_err_on_empty, ovf_sticky, udf_sticky;
   logic       f_full, f_empty, f_af, f_ae, f_perr, f_uerr, f_ovf, f_udf;
   logic [4:0] count, f_count;
   int         n_chk = 0, n_fail = 0;
   logic [7:0] q[$];
   logic [7:0] exp_dout = 0;

   fifo_gen2 dut (.clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .push_err_on_full(push_err_on_full), .pop_err_on_empty(pop_err_on_empty),
      .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky));
   fifo_gen2 #(.FWFT(1)) dut_fwft (.clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
      .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .push_err_on_full(f_perr), .pop_err_on_empty(f_uerr),
      .ovf_sticky(f_ovf), .udf_sticky(f_udf));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   // One clock of stimulus; the queue model tracks accepted operations.
   task automatic cyc(input logic p, input logic r, input logic [7:0] d);
      int pre;
      push = p; pop = r; data_in = d;
      pre = q.size();
      if (r && pre > 0) exp_dout = q.pop_front();
      if (p && pre < 16) q.push_back(d);
      @(posedge clk); #1;
      push = 0; pop = 0; clr_err = 0;
   endtask

   task automatic do_reset();
      rst_n = 0; q.delete(); exp_dout = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      n_chk++;
      if ({count, empty, almost_empty, full, almost_full} !== {5'd0, 4'b1100}) begin
         n_fail++; $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0", count, empty, almost_empty, full, almost_full);
      end
      n_chk++;
      if ({data_out, push_err_on_full, pop_err_on_empty, ovf_sticky, udf_sticky} !== 12'h0) begin
         n_fail++; $display("FAIL reset_out: got dout=%h pe=%b ue=%b ovf=%b udf=%b, want all 0", data_out, push_err_on_full, pop_err_on_empty, ovf_sticky, udf_sticky);
      end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 0, 8'(i));
         n_chk++;
         if (count !== 5'(i) || almost_full !== (i >= 12) || full !== (i == 16) || empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b e=%b", i, count, almost_full, full, empty);
         end
      end
      cyc(1, 0, 8'h11);
      n_chk++;
      if (push_err_on_full !== 1'b1 || ovf_sticky !== 1'b1 || count !== 5'd16) begin
         n_fail++; $display("FAIL fill_ovf: got pe=%b ovf=%b cnt=%0d, want 1 1 16", push_err_on_full, ovf_sticky, count);
      end
      cyc(0, 0, 0);
      n_chk++;
      if (push_err_on_full !== 1'b0 || ovf_sticky !== 1'b1) begin
         n_fail++; $display("FAIL fill_pulse: got pe=%b ovf=%b, want 0 1", push_err_on_full, ovf_sticky);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 1, 0);
         n_chk++;
         if (data_out !== 8'(i) || count !== 5'(16 - i) || almost_empty !== (16 - i <= 4) || empty !== (i == 16)) begin
            n_fail++; $display("FAIL drain_%0d: got dout=%h cnt=%0d ae=%b e=%b, want dout=%h", i, data_out, count, almost_empty, empty, 8'(i));
         end
      end
      cyc(0, 1, 0);
      n_chk++;
      if (pop_err_on_empty !== 1'b1 || udf_sticky !== 1'b1 || data_out !== 8'h10) begin
         n_fail++; $display("FAIL drain_udf: got ue=%b udf=%b dout=%h, want 1 1 10", pop_err_on_empty, udf_sticky, data_out);
      end
      cyc(0, 0, 0);
      n_chk++;
      if (pop_err_on_empty !== 1'b0 || data_out !== 8'h10) begin
         n_fail++; $display("FAIL drain_hold: got ue=%b dout=%h, want 0 10", pop_err_on_empty, data_out);
      end
   endtask

   task automatic test_clear();
      clr_err = 1; cyc(0, 0, 0);
      n_chk++;
      if (ovf_sticky !== 1'b0 || udf_sticky !== 1'b0) begin
         n_fail++; $display("FAIL clear: got ovf=%b udf=%b, want 0 0", ovf_sticky, udf_sticky);
      end
      clr_err = 1; cyc(0, 1, 0);
      n_chk++;
      if (udf_sticky !== 1'b1) begin
         n_fail++; $display("FAIL clear_set_wins: got udf=%b, want 1", udf_sticky);
      end
      clr_err = 1; cyc(0, 0, 0);
   endtask

   task automatic test_simul();
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'h20 + 8'(i));
      cyc(1, 1, 8'h28);
      n_chk++;
      if (count !== 5'd8 || data_out !== 8'h20) begin
         n_fail++; $display("FAIL simul_mid: got cnt=%0d dout=%h, want 8 20", count, data_out);
      end
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'h29 + 8'(i));
      cyc(1, 1, 8'h99);
      n_chk++;
      if (count !== 5'd15 || push_err_on_full !== 1'b1 || data_out !== 8'h21) begin
         n_fail++; $display("FAIL simul_full: got cnt=%0d pe=%b dout=%h, want 15 1 21", count, push_err_on_full, data_out);
      end
      for (int i = 0; i < 15; i++) begin
         cyc(0, 1, 0);
         n_chk++;
         if (data_out !== exp_dout) begin
            n_fail++; $display("FAIL simul_order_%0d: got %h want %h", i, data_out, exp_dout);
         end
      end
      cyc(1, 1, 8'h55);
      n_chk++;
      if (count !== 5'd1 || pop_err_on_empty !== 1'b1 || empty !== 1'b0) begin
         n_fail++; $display("FAIL simul_empty: got cnt=%0d ue=%b e=%b, want 1 1 0", count, pop_err_on_empty, empty);
      end
      cyc(0, 1, 0);
      n_chk++;
      if (data_out !== 8'h55) begin
         n_fail++; $display("FAIL simul_bypass: got %h want 55", data_out);
      end
      clr_err = 1; cyc(0, 0, 0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) begin
         cyc(i < 24, i >= 16, 8'(i * 37 + 5));
         n_chk++;
         if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0) ||
             almost_full !== (q.size() >= 12) || almost_empty !== (q.size() <= 4) || data_out !== exp_dout) begin
            n_fail++; $display("FAIL wrap_%0d: got cnt=%0d f=%b e=%b af=%b ae=%b dout=%h, want cnt=%0d dout=%h",
               i, count, full, empty, almost_full, almost_empty, data_out, q.size(), exp_dout);
         end
      end
      clr_err = 1; cyc(0, 0, 0);
   endtask

   task automatic test_fwft();
      do_reset();
      cyc(1, 0, 8'hA5);
      n_chk++;
      if (f_empty !== 1'b0 || f_data_out !== 8'hA5) begin
         n_fail++; $display("FAIL fwft_first: got e=%b dout=%h, want 0 a5", f_empty, f_data_out);
      end
      cyc(1, 0, 8'h5A);
      n_chk++;
      if (f_data_out !== 8'hA5) begin
         n_fail++; $display("FAIL fwft_head: got %h want a5", f_data_out);
      end
      cyc(0, 1, 0);
      n_chk++;
      if (f_data_out !== 8'h5A || f_empty !== 1'b0) begin
         n_fail++; $display("FAIL fwft_next: got e=%b dout=%h, want 0 5a", f_empty, f_data_out);
      end
      cyc(0, 1, 0);
      n_chk++;
      if (f_empty !== 1'b1) begin
         n_fail++; $display("FAIL fwft_empty: got e=%b want 1", f_empty);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 17; i++) cyc(1, 0, 8'(i));
      for (int i = 0; i < 9; i++) cyc(0, 1, 0);
      n_chk++;
      if (count !== 5'd7 || ovf_sticky !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre: got cnt=%0d ovf=%b, want 7 1", count, ovf_sticky);
      end
      #2 rst_n = 0;
      #1;
      n_chk++;
      if (count !== 5'd0 || empty !== 1'b1 || ovf_sticky !== 1'b0 || data_out !== 8'h00) begin
         n_fail++; $display("FAIL rmid_async: got cnt=%0d e=%b ovf=%b dout=%h, want 0 1 0 00", count, empty, ovf_sticky, data_out);
      end
      q.delete(); exp_dout = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      cyc(1, 0, 8'h3C);
      cyc(0, 1, 0);
      n_chk++;
      if (data_out !== 8'h3C || empty !== 1'b1) begin
         n_fail++; $display("FAIL rmid_after: got dout=%h e=%b, want 3c 1", data_out, empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_clear();
      test_simul();
      test_wrap();
      test_fwft();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
